// File: rtl/rs_unit_multi.sv
// rs_unit_multi -- shared reservation station feeding NUM_CLASSES functional
// unit classes.
//
// Ports:
//   clk, reset (sync, active-high), flush (sync squash)
//   disp_*      : dispatch handshake and instruction fields
//   cdb_*       : result broadcast (wakes waiting operands, clears busy)
//   iss_valid/iss_ready : per-class issue handshake
//   iss_op/opa/opb/dst/tag : packed per-class payloads, class c at slice c
//   occupancy   : number of valid entries
module rs_unit_multi #(
   parameter int unsigned RS_ENTRIES  = 8,
   parameter int unsigned NUM_CLASSES = 2,
   parameter int unsigned VAL_W       = 32,
   parameter int unsigned PREG_W      = 6,
   parameter int unsigned TAG_W       = 5,
   parameter int unsigned OP_W        = 8
) (
   input  logic                                              clk,
   input  logic                                              reset,
   input  logic                                              flush,
   input  logic                                              disp_valid,
   output logic                                              disp_ready,
   input  logic [(NUM_CLASSES > 1 ? $clog2(NUM_CLASSES) : 1)-1:0] disp_class,
   input  logic [OP_W-1:0]                                   disp_op,
   input  logic [PREG_W-1:0]                                 disp_src1_addr,
   input  logic [PREG_W-1:0]                                 disp_src2_addr,
   input  logic [VAL_W-1:0]                                  disp_src1_val,
   input  logic [VAL_W-1:0]                                  disp_src2_val,
   input  logic                                              disp_src2_is_imm,
   input  logic [VAL_W-1:0]                                  disp_imm,
   input  logic [PREG_W-1:0]                                 disp_dst_addr,
   input  logic                                              disp_dst_wr,
   input  logic [TAG_W-1:0]                                  disp_tag,
   input  logic                                              cdb_valid,
   input  logic [PREG_W-1:0]                                 cdb_preg,
   input  logic [VAL_W-1:0]                                  cdb_val,
   output logic [NUM_CLASSES-1:0]                            iss_valid,
   input  logic [NUM_CLASSES-1:0]                            iss_ready,
   output logic [NUM_CLASSES*OP_W-1:0]                       iss_op,
   output logic [NUM_CLASSES*VAL_W-1:0]                      iss_opa,
   output logic [NUM_CLASSES*VAL_W-1:0]                      iss_opb,
   output logic [NUM_CLASSES*PREG_W-1:0]                     iss_dst,
   output logic [NUM_CLASSES*TAG_W-1:0]                      iss_tag,
   output logic [$clog2(RS_ENTRIES+1)-1:0]                   occupancy
);

   localparam int unsigned CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
   localparam int unsigned IDX_W = $clog2(RS_ENTRIES);
   localparam int unsigned OCC_W = $clog2(RS_ENTRIES+1);
   localparam int unsigned NPREG = 1 << PREG_W;

   // entry state
   logic [RS_ENTRIES-1:0] r_valid;
   logic [RS_ENTRIES-1:0] r_pa;
   logic [RS_ENTRIES-1:0] r_pb;
   logic [CLS_W-1:0]      r_cls [RS_ENTRIES];
   logic [OP_W-1:0]       r_op  [RS_ENTRIES];
   logic [VAL_W-1:0]      r_va  [RS_ENTRIES];
   logic [VAL_W-1:0]      r_vb  [RS_ENTRIES];
   logic [PREG_W-1:0]     r_wa  [RS_ENTRIES];
   logic [PREG_W-1:0]     r_wb  [RS_ENTRIES];
   logic [PREG_W-1:0]     r_dst [RS_ENTRIES];
   logic [TAG_W-1:0]      r_tag [RS_ENTRIES];
   // r_older[j][i] = entry j was accepted before entry i. A relative-age matrix
   // never wraps, so ordering survives unlimited dispatch/issue sequences.
   logic [RS_ENTRIES-1:0] r_older [RS_ENTRIES];
   logic [NPREG-1:0]      r_busy;

   logic                  w_accept;
   logic [IDX_W-1:0]      w_free_idx;
   logic                  w_s1_cdb, w_s2_cdb;
   logic                  w_s1_pend, w_s2_pend;
   logic [VAL_W-1:0]      w_s1_val, w_s2_val;
   logic [RS_ENTRIES-1:0] w_rdy;
   logic [RS_ENTRIES-1:0] w_sel [NUM_CLASSES];
   logic [RS_ENTRIES-1:0] w_issue_clr;
   logic [OCC_W-1:0]      w_occ;

   // free slot search works on registered valid bits only, so a slot vacated
   // by this cycle's issue is not reused until the next cycle
   assign disp_ready = ~&r_valid;
   assign w_accept   = disp_valid && disp_ready;

   always_comb begin
      w_free_idx = '0;
      for (int unsigned i = RS_ENTRIES; i > 0; i--) begin
         if (!r_valid[i-1]) w_free_idx = IDX_W'(i-1);
      end
   end

   // operand capture at dispatch, with same-cycle CDB bypass
   always_comb begin
      w_s1_cdb  = cdb_valid && (cdb_preg == disp_src1_addr);
      w_s2_cdb  = cdb_valid && (cdb_preg == disp_src2_addr);
      w_s1_pend = r_busy[disp_src1_addr] && !w_s1_cdb;
      w_s2_pend = !disp_src2_is_imm && r_busy[disp_src2_addr] && !w_s2_cdb;
      w_s1_val  = w_s1_cdb ? cdb_val : disp_src1_val;
      if (disp_src2_is_imm) w_s2_val = disp_imm;
      else if (w_s2_cdb)    w_s2_val = cdb_val;
      else                  w_s2_val = disp_src2_val;
   end

   // per-class oldest-ready select: a ready entry wins unless some other ready
   // entry of the same class is older; payload is an AND-OR of the one-hot pick
   always_comb begin
      w_rdy       = r_valid & ~r_pa & ~r_pb;
      w_issue_clr = '0;
      iss_valid   = '0;
      iss_op      = '0;
      iss_opa     = '0;
      iss_opb     = '0;
      iss_dst     = '0;
      iss_tag     = '0;
      for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
         w_sel[c] = '0;
         for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
            if (w_rdy[i] && (r_cls[i] == CLS_W'(c))) begin
               w_sel[c][i] = 1'b1;
               for (int unsigned j = 0; j < RS_ENTRIES; j++) begin
                  if (w_rdy[j] && (r_cls[j] == CLS_W'(c)) && r_older[j][i])
                     w_sel[c][i] = 1'b0;
               end
            end
         end
         iss_valid[c] = |w_sel[c];
         for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
            if (w_sel[c][i]) begin
               iss_op [c*OP_W   +: OP_W]   = r_op[i];
               iss_opa[c*VAL_W  +: VAL_W]  = r_va[i];
               iss_opb[c*VAL_W  +: VAL_W]  = r_vb[i];
               iss_dst[c*PREG_W +: PREG_W] = r_dst[i];
               iss_tag[c*TAG_W  +: TAG_W]  = r_tag[i];
            end
         end
         if (iss_ready[c]) w_issue_clr = w_issue_clr | w_sel[c];
      end
   end

   always_comb begin
      w_occ = '0;
      for (int unsigned i = 0; i < RS_ENTRIES; i++) w_occ = w_occ + OCC_W'(r_valid[i]);
   end
   assign occupancy = w_occ;

   // control state: valid bits and register busy table
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_valid <= '0;
         r_busy  <= '0;
      end else begin
         r_valid <= r_valid & ~w_issue_clr;
         if (cdb_valid) r_busy[cdb_preg] <= 1'b0;
         if (w_accept) begin
            r_valid[w_free_idx] <= 1'b1;
            // written after the CDB clear so a same-cycle set wins
            if (disp_dst_wr && (disp_dst_addr != '0)) r_busy[disp_dst_addr] <= 1'b1;
         end
      end
   end

   // entry payload, wakeup and age; only meaningful while the entry is valid
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
         if (cdb_valid && r_valid[i] && r_pa[i] && (r_wa[i] == cdb_preg)) begin
            r_pa[i] <= 1'b0;
            r_va[i] <= cdb_val;
         end
         if (cdb_valid && r_valid[i] && r_pb[i] && (r_wb[i] == cdb_preg)) begin
            r_pb[i] <= 1'b0;
            r_vb[i] <= cdb_val;
         end
      end
      if (w_accept) begin
         r_cls[w_free_idx]   <= disp_class;
         r_op[w_free_idx]    <= disp_op;
         r_va[w_free_idx]    <= w_s1_val;
         r_vb[w_free_idx]    <= w_s2_val;
         r_pa[w_free_idx]    <= w_s1_pend;
         r_pb[w_free_idx]    <= w_s2_pend;
         r_wa[w_free_idx]    <= disp_src1_addr;
         r_wb[w_free_idx]    <= disp_src2_addr;
         r_dst[w_free_idx]   <= disp_dst_addr;
         r_tag[w_free_idx]   <= disp_tag;
         r_older[w_free_idx] <= '0;
         for (int unsigned j = 0; j < RS_ENTRIES; j++) begin
            if (IDX_W'(j) != w_free_idx) r_older[j][w_free_idx] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_rs_unit_multi.sv
module tb_rs_unit_multi;

   localparam int RS = 8;
   localparam int NC = 2;
   localparam int VW = 32;
   localparam int PW = 6;
   localparam int TW = 5;
   localparam int OW = 8;
   localparam int CW = 1;

   logic              clk = 1'b0;
   logic              reset, flush;
   logic              disp_valid, disp_ready;
   logic [CW-1:0]     disp_class;
   logic [OW-1:0]     disp_op;
   logic [PW-1:0]     disp_src1_addr, disp_src2_addr;
   logic [VW-1:0]     disp_src1_val, disp_src2_val;
   logic              disp_src2_is_imm;
   logic [VW-1:0]     disp_imm;
   logic [PW-1:0]     disp_dst_addr;
   logic              disp_dst_wr;
   logic [TW-1:0]     disp_tag;
   logic              cdb_valid;
   logic [PW-1:0]     cdb_preg;
   logic [VW-1:0]     cdb_val;
   logic [NC-1:0]     iss_valid, iss_ready;
   logic [NC*OW-1:0]  iss_op;
   logic [NC*VW-1:0]  iss_opa, iss_opb;
   logic [NC*PW-1:0]  iss_dst;
   logic [NC*TW-1:0]  iss_tag;
   logic [3:0]        occupancy;

   int checks = 0;
   int errors = 0;

   rs_unit_multi #(.RS_ENTRIES(RS), .NUM_CLASSES(NC), .VAL_W(VW), .PREG_W(PW),
                   .TAG_W(TW), .OP_W(OW)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_class(disp_class),
      .disp_op(disp_op), .disp_src1_addr(disp_src1_addr), .disp_src2_addr(disp_src2_addr),
      .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
      .disp_src2_is_imm(disp_src2_is_imm), .disp_imm(disp_imm),
      .disp_dst_addr(disp_dst_addr), .disp_dst_wr(disp_dst_wr), .disp_tag(disp_tag),
      .cdb_valid(cdb_valid), .cdb_preg(cdb_preg), .cdb_val(cdb_val),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
      .iss_opa(iss_opa), .iss_opb(iss_opb), .iss_dst(iss_dst), .iss_tag(iss_tag),
      .occupancy(occupancy));

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flush = 0; disp_valid = 0; disp_class = '0; disp_op = '0;
      disp_src1_addr = '0; disp_src2_addr = '0; disp_src1_val = '0; disp_src2_val = '0;
      disp_src2_is_imm = 0; disp_imm = '0; disp_dst_addr = '0; disp_dst_wr = 0;
      disp_tag = '0; cdb_valid = 0; cdb_preg = '0; cdb_val = '0; iss_ready = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      cyc();
      cyc();
      reset = 0;
   endtask

   task automatic set_disp(input int cls, input int s1, input logic [VW-1:0] v1,
                           input int s2, input logic [VW-1:0] v2, input bit imm,
                           input logic [VW-1:0] immv, input int dst, input bit wr,
                           input int tag, input logic [OW-1:0] op);
      disp_valid = 1; disp_class = CW'(cls); disp_op = op;
      disp_src1_addr = PW'(s1); disp_src1_val = v1;
      disp_src2_addr = PW'(s2); disp_src2_val = v2;
      disp_src2_is_imm = imm; disp_imm = immv;
      disp_dst_addr = PW'(dst); disp_dst_wr = wr; disp_tag = TW'(tag);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", disp_ready); end
      checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL rst_iss_valid got %b exp 00", iss_valid); end
      checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL rst_occ got %0d exp 0", occupancy); end
      checks++; if ({iss_op, iss_opa, iss_opb, iss_dst, iss_tag} !== '0) begin
         errors++; $display("FAIL rst_payload got %h/%h/%h exp 0", iss_op, iss_opa, iss_opb); end
   endtask

   task automatic test_basic();
      do_reset();
      iss_ready = 2'b11;
      set_disp(0, 5, 10, 6, 20, 0, 0, 3, 1, 1, 8'hA1);
      cyc();
      disp_valid = 0;
      checks++; if (iss_valid !== 2'b01) begin errors++; $display("FAIL basic_valid got %b exp 01", iss_valid); end
      checks++; if (iss_opa[VW-1:0] !== 32'd10) begin errors++; $display("FAIL basic_opa got %0d exp 10", iss_opa[VW-1:0]); end
      checks++; if (iss_opb[VW-1:0] !== 32'd20) begin errors++; $display("FAIL basic_opb got %0d exp 20", iss_opb[VW-1:0]); end
      checks++; if ({iss_op[OW-1:0], iss_dst[PW-1:0], iss_tag[TW-1:0]} !== {8'hA1, 6'd3, 5'd1}) begin
         errors++; $display("FAIL basic_fields got %h/%0d/%0d exp a1/3/1", iss_op[OW-1:0], iss_dst[PW-1:0], iss_tag[TW-1:0]); end
      checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL basic_occ1 got %0d exp 1", occupancy); end
      cyc();
      checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL basic_occ0 got %0d exp 0", occupancy); end
      checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL basic_drain got %b exp 00", iss_valid); end
   endtask

   task automatic test_dependency();
      do_reset();
      iss_ready = 2'b11;
      set_disp(0, 1, 0, 2, 0, 0, 0, 7, 1, 2, 8'h10);
      cyc();
      set_disp(1, 7, 32'hDEAD, 0, 0, 1, 32'h44, 8, 1, 3, 8'h20);
      cyc();
      disp_valid = 0;
      checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL dep_wait got %b exp 00", iss_valid); end
      checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL dep_occ got %0d exp 1", occupancy); end
      cyc();
      checks++; if (iss_valid[1] !== 1'b0) begin errors++; $display("FAIL dep_still got %b exp 0", iss_valid[1]); end
      cdb_valid = 1; cdb_preg = 7; cdb_val = 32'h55;
      cyc();
      cdb_valid = 0;
      checks++; if (iss_valid !== 2'b10) begin errors++; $display("FAIL dep_wake got %b exp 10", iss_valid); end
      checks++; if (iss_opa[2*VW-1:VW] !== 32'h55) begin errors++; $display("FAIL dep_opa got %h exp 55", iss_opa[2*VW-1:VW]); end
      checks++; if (iss_opb[2*VW-1:VW] !== 32'h44) begin errors++; $display("FAIL dep_opb got %h exp 44", iss_opb[2*VW-1:VW]); end
      cyc();
      checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL dep_occ0 got %0d exp 0", occupancy); end
      // preg 7 no longer busy: a reader takes the register-file value at once
      set_disp(0, 7, 32'h99, 0, 0, 0, 0, 0, 0, 4, 8'h30);
      cyc();
      disp_valid = 0;
      checks++; if (iss_valid[0] !== 1'b1 || iss_opa[VW-1:0] !== 32'h99) begin
         errors++; $display("FAIL dep_busy_clr got %b/%h exp 1/99", iss_valid[0], iss_opa[VW-1:0]); end
   endtask

   task automatic test_bypass();
      do_reset();
      set_disp(1, 0, 0, 0, 0, 0, 0, 9, 1, 5, 8'h01);
      cyc();
      set_disp(0, 9, 32'h77, 0, 32'h8, 0, 0, 10, 1, 6, 8'h02);
      cdb_valid = 1; cdb_preg = 9; cdb_val = 32'h3;
      cyc();
      disp_valid = 0; cdb_valid = 0;
      checks++; if (iss_valid !== 2'b11) begin errors++; $display("FAIL byp_valid got %b exp 11", iss_valid); end
      checks++; if (iss_opa[VW-1:0] !== 32'h3) begin errors++; $display("FAIL byp_opa got %h exp 3", iss_opa[VW-1:0]); end
      checks++; if (iss_opb[VW-1:0] !== 32'h8) begin errors++; $display("FAIL byp_opb got %h exp 8", iss_opb[VW-1:0]); end
      checks++; if (occupancy !== 4'd2) begin errors++; $display("FAIL byp_occ got %0d exp 2", occupancy); end
   endtask

   task automatic test_fill();
      do_reset();
      iss_ready = 2'b10;
      set_disp(1, 0, 0, 0, 0, 0, 0, 12, 1, 31, 8'hFF);
      cyc();
      for (int k = 0; k < 8; k++) begin
         checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d got %b exp 1", k, disp_ready); end
         set_disp(0, 12, 32'hBAD, 0, 0, 1, 32'(k), 0, 0, k, 8'(k));
         cyc();
      end
      disp_valid = 0; iss_ready = 2'b00;
      checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL fill_occ got %0d exp 8", occupancy); end
      checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL fill_full got %b exp 0", disp_ready); end
      checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL fill_pend got %b exp 00", iss_valid); end
      cdb_valid = 1; cdb_preg = 12; cdb_val = 32'h1234;
      cyc();
      cdb_valid = 0; iss_ready = 2'b01;
      for (int k = 0; k < 8; k++) begin
         checks++; if (iss_valid[0] !== 1'b1 || iss_tag[TW-1:0] !== TW'(k)) begin
            errors++; $display("FAIL fill_order%0d got %b/%0d exp 1/%0d", k, iss_valid[0], iss_tag[TW-1:0], k); end
         checks++; if (iss_opa[VW-1:0] !== 32'h1234 || iss_opb[VW-1:0] !== 32'(k)) begin
            errors++; $display("FAIL fill_ops%0d got %h/%h exp 1234/%h", k, iss_opa[VW-1:0], iss_opb[VW-1:0], k); end
         cyc();
         if (k == 0) begin
            checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL fill_reopen got %b exp 1", disp_ready); end
         end
      end
      checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL fill_drain got %0d exp 0", occupancy); end
   endtask

   task automatic test_dual();
      do_reset();
      set_disp(0, 0, 1, 0, 2, 0, 0, 0, 0, 1, 8'h11);
      cyc();
      set_disp(1, 0, 3, 0, 4, 0, 0, 0, 0, 2, 8'h22);
      cyc();
      disp_valid = 0;
      checks++; if (iss_valid !== 2'b11) begin errors++; $display("FAIL dual_valid got %b exp 11", iss_valid); end
      checks++; if (occupancy !== 4'd2) begin errors++; $display("FAIL dual_occ2 got %0d exp 2", occupancy); end
      iss_ready = 2'b11;
      cyc();
      checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL dual_occ0 got %0d exp 0", occupancy); end
      checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL dual_drain got %b exp 00", iss_valid); end
   endtask

   task automatic test_flush();
      do_reset();
      for (int k = 0; k < 5; k++) begin
         set_disp(k % 2, (k == 0) ? 0 : 19 + k, 0, 0, 0, 0, 0, 20 + k, 1, k, 8'(k));
         cyc();
      end
      disp_valid = 0;
      checks++; if (occupancy !== 4'd5) begin errors++; $display("FAIL flush_pre got %0d exp 5", occupancy); end
      flush = 1;
      set_disp(0, 0, 0, 0, 0, 0, 0, 30, 1, 9, 8'h99);
      cdb_valid = 1; cdb_preg = 20; cdb_val = 32'h1;
      cyc();
      flush = 0; disp_valid = 0; cdb_valid = 0;
      checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL flush_occ got %0d exp 0", occupancy); end
      checks++; if (iss_valid !== 2'b00) begin errors++; $display("FAIL flush_valid got %b exp 00", iss_valid); end
      checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", disp_ready); end
      checks++; if ({iss_op, iss_opa, iss_opb, iss_dst, iss_tag} !== '0) begin
         errors++; $display("FAIL flush_payload got %h/%h exp 0", iss_opa, iss_opb); end
      set_disp(0, 21, 32'h5A, 30, 32'h6B, 0, 0, 22, 1, 10, 8'h55);
      cyc();
      disp_valid = 0;
      checks++; if (iss_valid !== 2'b01 || iss_opa[VW-1:0] !== 32'h5A || iss_opb[VW-1:0] !== 32'h6B) begin
         errors++; $display("FAIL flush_busy got %b/%h/%h exp 01/5a/6b", iss_valid, iss_opa[VW-1:0], iss_opb[VW-1:0]); end
   endtask

   // reference: instructions kept in a queue in acceptance order
   typedef struct {
      int cls; logic [OW-1:0] op; logic [VW-1:0] a, b;
      bit pa, pb; int wa, wb; logic [PW-1:0] dst; logic [TW-1:0] tag;
   } ent_t;

   task automatic test_random();
      ent_t q[$];
      ent_t nq[$];
      ent_t ne;
      bit mbusy [64];
      int sel [NC];
      logic [NC-1:0] e_valid;
      logic [NC*OW-1:0] e_op;
      logic [NC*VW-1:0] e_opa, e_opb;
      logic [NC*PW-1:0] e_dst;
      logic [NC*TW-1:0] e_tag;
      bit keep;
      do_reset();
      for (int p = 0; p < 64; p++) mbusy[p] = 0;
      for (int cy = 0; cy < 3000; cy++) begin
         disp_valid = ($urandom_range(0, 9) < 6);
         disp_class = CW'($urandom_range(0, 1));
         disp_op = OW'($urandom); disp_tag = TW'($urandom);
         disp_src1_addr = PW'($urandom_range(0, 7)); disp_src2_addr = PW'($urandom_range(0, 7));
         disp_src1_val = $urandom; disp_src2_val = $urandom;
         disp_src2_is_imm = ($urandom_range(0, 3) == 0); disp_imm = $urandom;
         disp_dst_addr = PW'($urandom_range(0, 7)); disp_dst_wr = ($urandom_range(0, 9) < 7);
         cdb_valid = ($urandom_range(0, 9) < 4); cdb_preg = PW'($urandom_range(1, 7)); cdb_val = $urandom;
         iss_ready = NC'($urandom_range(0, 3));
         flush = ($urandom_range(0, 99) == 0);
         // expected outputs: oldest non-waiting instruction of each class
         e_valid = '0; e_op = '0; e_opa = '0; e_opb = '0; e_dst = '0; e_tag = '0;
         for (int c = 0; c < NC; c++) begin
            sel[c] = -1;
            for (int i = 0; i < q.size(); i++) begin
               if (sel[c] < 0 && q[i].cls == c && !q[i].pa && !q[i].pb) begin
                  sel[c] = i; e_valid[c] = 1'b1;
                  e_op[c*OW +: OW] = q[i].op; e_opa[c*VW +: VW] = q[i].a; e_opb[c*VW +: VW] = q[i].b;
                  e_dst[c*PW +: PW] = q[i].dst; e_tag[c*TW +: TW] = q[i].tag;
               end
            end
         end
         checks++; if (disp_ready !== (q.size() < RS)) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", cy, disp_ready, q.size() < RS); end
         checks++; if (occupancy !== 4'(q.size())) begin errors++; $display("FAIL rnd_occ cyc %0d got %0d exp %0d", cy, occupancy, q.size()); end
         checks++; if (iss_valid !== e_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", cy, iss_valid, e_valid); end
         checks++; if (iss_op !== e_op || iss_tag !== e_tag || iss_dst !== e_dst) begin
            errors++; $display("FAIL rnd_fields cyc %0d got %h/%h/%h exp %h/%h/%h", cy, iss_op, iss_tag, iss_dst, e_op, e_tag, e_dst); end
         checks++; if (iss_opa !== e_opa || iss_opb !== e_opb) begin
            errors++; $display("FAIL rnd_ops cyc %0d got %h/%h exp %h/%h", cy, iss_opa, iss_opb, e_opa, e_opb); end
         // advance the reference across the clock edge
         if (flush) begin
            q.delete();
            for (int p = 0; p < 64; p++) mbusy[p] = 0;
         end else begin
            ne.cls = int'(disp_class); ne.op = disp_op; ne.dst = disp_dst_addr; ne.tag = disp_tag;
            ne.wa = int'(disp_src1_addr); ne.wb = int'(disp_src2_addr);
            ne.pa = mbusy[ne.wa] && !(cdb_valid && cdb_preg == disp_src1_addr);
            ne.a = (cdb_valid && cdb_preg == disp_src1_addr) ? cdb_val : disp_src1_val;
            if (disp_src2_is_imm) begin
               ne.pb = 0; ne.b = disp_imm;
            end else begin
               ne.pb = mbusy[ne.wb] && !(cdb_valid && cdb_preg == disp_src2_addr);
               ne.b = (cdb_valid && cdb_preg == disp_src2_addr) ? cdb_val : disp_src2_val;
            end
            nq.delete();
            for (int i = 0; i < q.size(); i++) begin
               keep = 1;
               for (int c = 0; c < NC; c++) if (sel[c] == i && iss_ready[c]) keep = 0;
               if (keep) begin
                  if (cdb_valid && q[i].pa && q[i].wa == int'(cdb_preg)) begin q[i].pa = 0; q[i].a = cdb_val; end
                  if (cdb_valid && q[i].pb && q[i].wb == int'(cdb_preg)) begin q[i].pb = 0; q[i].b = cdb_val; end
                  nq.push_back(q[i]);
               end
            end
            if (cdb_valid) mbusy[int'(cdb_preg)] = 0;
            if (disp_valid && q.size() < RS) begin
               nq.push_back(ne);
               if (disp_dst_wr && disp_dst_addr != 0) mbusy[int'(disp_dst_addr)] = 1;
            end
            q = nq;
         end
         cyc();
      end
      idle_inputs();
   endtask

   initial begin
      reset = 1;
      idle_inputs();
      test_reset();
      test_basic();
      test_dependency();
      test_bypass();
      test_fill();
      test_dual();
      test_flush();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rs_unit_multi.md
RS_UNIT_MULTI -- requirements
Module: rs_unit_multi

Interface
REQ-001 Parameters (name, default, meaning) SHALL be as follows.
- RS_ENTRIES, 8: shared station entries, power of two, 2..32.
- NUM_CLASSES, 2: FU classes, 1..4.
- VAL_W, 32: operand width.
- PREG_W, 6: physical register address width.
- TAG_W, 5: ROB tag width.
- OP_W, 8: opaque control payload width.
REQ-002 Ports (name, direction, width, meaning) SHALL be as follows.
- clk, in, 1: single clock.
- reset, in, 1: synchronous, active-high.
- flush, in, 1: synchronous squash.
- disp_valid, in, 1 / disp_ready, out, 1: dispatch handshake.
- disp_class, in, max(1,$clog2(NUM_CLASSES)): target FU class.
- disp_op, in, OP_W: control payload.
- disp_src1_addr / disp_src2_addr, in, PREG_W: source physical registers.
- disp_src1_val / disp_src2_val, in, VAL_W: register-file values.
- disp_src2_is_imm, in, 1: operand B is disp_imm.
- disp_imm, in, VAL_W: immediate.
- disp_dst_addr, in, PREG_W: destination.
- disp_dst_wr, in, 1: instruction writes a register.
- disp_tag, in, TAG_W: ROB tag.
- cdb_valid, in, 1 / cdb_preg, in, PREG_W / cdb_val, in, VAL_W: result broadcast.
- iss_valid, out, NUM_CLASSES / iss_ready, in, NUM_CLASSES: per-class issue handshake.
- iss_op, out, NUM_CLASSES*OP_W; iss_opa / iss_opb, out, NUM_CLASSES*VAL_W; iss_dst, out, NUM_CLASSES*PREG_W; iss_tag, out, NUM_CLASSES*TAG_W: packed issue payloads, class c at slice c.
- occupancy, out, $clog2(RS_ENTRIES+1): valid entry count.

Function
REQ-003 Each entry SHALL hold: valid, class, op, opA/opB value, opA/opB pending flag, opA/opB waited preg, dst, tag, and age order.
REQ-004 A register status table SHALL hold one busy bit per physical register; preg 0 SHALL never be busy.
REQ-005 disp_ready SHALL be 1 when any entry is invalid. It SHALL be computed from registered state only; an entry freed by issue in the same cycle is not reusable until the next cycle.
REQ-006 On accept (disp_valid && disp_ready), the lowest-index free entry SHALL be written at the clock edge.
REQ-007 A source operand SHALL be pending iff busy[src] && !(cdb_valid && cdb_preg==src). A same-cycle CDB match SHALL capture cdb_val (bypass); otherwise the operand captures disp_srcN_val.
REQ-008 When disp_src2_is_imm=1, opB SHALL take disp_imm and SHALL never be pending.
REQ-009 On accept with disp_dst_wr=1 and dst!=0, busy[dst] SHALL be set. If a CDB clear for the same preg occurs in the same cycle, the set SHALL win.
REQ-010 On cdb_valid, busy[cdb_preg] SHALL clear. Every valid entry operand pending on cdb_preg SHALL capture cdb_val and clear its pending flag at that edge.
REQ-011 An entry SHALL be issue-ready when valid and neither operand is pending; readiness is visible the cycle after the capturing edge (no CDB-to-issue combinational path).
REQ-012 For each class c, iss_valid[c] SHALL be 1 iff a ready entry of class c exists. The payload SHALL be that of the oldest (earliest accepted) such entry, driven combinationally from entry state.
REQ-013 On iss_valid[c] && iss_ready[c], the selected entry SHALL be invalidated at the edge. Classes issue independently, up to NUM_CLASSES per cycle.
REQ-014 While iss_valid[c]=1 and iss_ready[c]=0, the slice c payload SHALL be held stable unless an older class-c entry becomes ready.
REQ-015 Age order SHALL be preserved across any sequence of dispatch and issue, with no wrap-around error after unlimited operations.
REQ-016 occupancy SHALL equal the number of valid entries, updated at each edge by +accept -issues.
REQ-017 A disp_class value >= NUM_CLASSES SHALL be accepted but never issued; this is a documented misuse.

Reset
REQ-018 On reset or flush at a clock edge, all entries SHALL be invalidated and all busy bits cleared. Same-cycle dispatch and CDB SHALL be ignored.
REQ-019 After reset: disp_ready=1, iss_valid=0, occupancy=0. Payload outputs SHALL be 0.

Verification
REQ-020 The bench SHALL cover these scenarios.
- Dispatch class 0, src1=5, src2=6, both not busy, vals 10/20, iss_ready=1: iss_valid[0]=1 the next cycle, opa=10, opb=20, occupancy returns to 0.
- Dispatch A (dst=7), then B (src1=7) to class 1: B not issued. CDB preg 7 val 0x55: B issues one cycle later with opa=0x55; busy[7] cleared.
- Dispatch with src1=9 busy while cdb_valid, preg 9, val 0x3 in the same cycle: entry ready next cycle with opa=0x3 (bypass).
- Fill 8 entries with class-0 instructions pending on preg 12: disp_ready=0 and occupancy=8. CDB 12 clears all. Issue order matches dispatch order 0..7, one per cycle; disp_ready=1 after the first issue edge.
- Class 0 and class 1 entries ready simultaneously with iss_ready=2'b11: both issue in the same cycle, occupancy drops by 2.
- Flush asserted mid-operation with 5 entries valid and a simultaneous dispatch: next cycle occupancy=0, iss_valid=0, and all busy bits are clear (a subsequent dependent dispatch is immediately ready).
